// File: rtl/prvp_spi_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prvp_spi_ctrl_pkg
// Description : Shared FSM state encoding and default sizing for the C2C SPI
//               master transaction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package prvp_spi_ctrl_pkg;

    localparam int c_DEF_DATA_W   = 32;
    localparam int c_DEF_CS_SETUP = 2;
    localparam int c_DEF_CS_HOLD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prvp_spi_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : prvp_spi_master_ctrl_if
// Description : Request/response handshake bundle between the command logic
//               (master) and the SPI transaction sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface prvp_spi_master_ctrl_if
    import prvp_spi_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic              req_valid;
    logic              req_ready;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_len, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_len, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/prvp_spi_ctrl_shreg.sv
`default_nettype none
// ============================================================================
// Module      : prvp_spi_ctrl_shreg
// Description : MSB-first TX shifter, optional RX shifter and bit counter.
//               RX path is built only when PRVP_SPI_CTRL_RX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module prvp_spi_ctrl_shreg
    import prvp_spi_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_shift_tx,
    input  wire logic              i_shift_rx,
    input  wire logic [LEN_W-1:0]  i_len,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_miso,
    output logic                   o_mosi,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_cnt_lt_len,
    output logic                   o_cnt_last
);

    localparam logic [LEN_W-1:0] c_DATA_W_L = LEN_W'(DATA_W);

    logic [DATA_W-1:0] r_tx;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_eff_len;

    always_comb begin
        w_eff_len = (i_len > c_DATA_W_L) ? c_DATA_W_L : i_len;
    end

    // TX word is left-justified at load so the MSB always carries the live bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx  <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_tx  <= i_wdata << (c_DATA_W_L - w_eff_len);
            r_len <= w_eff_len;
            r_cnt <= '0;
        end else begin
            if (i_shift_tx) begin
                r_tx <= r_tx << 1;
            end
            if (i_shift_rx) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    assign o_mosi       = r_tx[DATA_W-1];
    assign o_cnt_lt_len = (r_cnt < r_len);
    assign o_cnt_last   = (r_cnt == (r_len - LEN_W'(1)));

`ifdef PRVP_SPI_CTRL_RX_EN
    logic [DATA_W-1:0] r_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx <= '0;
        end else if (i_load) begin
            r_rx <= '0;
        end else if (i_shift_rx) begin
            r_rx <= {r_rx[DATA_W-2:0], i_miso};
        end
    end

    assign o_rdata = r_rx;
`else
    logic w_unused_rx;
    assign w_unused_rx = i_miso ^ i_shift_rx;
    assign o_rdata     = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/prvp_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prvp_spi_master_ctrl
// Description : SPI mode-0 transaction sequencer: chip-select, clock-enable
//               gating and shift control. Full-duplex when
//               PRVP_SPI_CTRL_RX_EN is defined, write-only otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module prvp_spi_master_ctrl
    import prvp_spi_ctrl_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int CS_SETUP = c_DEF_CS_SETUP,
    parameter int CS_HOLD  = c_DEF_CS_HOLD
) (
    input  wire logic             clk,
    input  wire logic             rst,
    prvp_spi_master_ctrl_if.slave bus,
    output logic                  clkgen_en,
    input  wire logic             spi_clk,
    input  wire logic             spi_rise,
    input  wire logic             spi_fall,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  wire logic             spi_miso
);

    localparam int c_LEN_W   = $clog2(DATA_W + 1);
    localparam int c_TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_SETUP_LAST = c_TMR_W'(CS_SETUP - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST  = c_TMR_W'(CS_HOLD - 1);

    state_t             r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic               r_cs_n;
    logic               r_clkgen_en;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_busy;

    logic               w_load;
    logic               w_shift_tx;
    logic               w_shift_rx;
    logic               w_cnt_lt_len;
    logic               w_cnt_last;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_unused_spi_clk;

    // Strobes are honoured only in SHIFT; TAIL watches spi_fall directly.
    assign w_load     = (r_state == ST_IDLE) && bus.req_valid;
    assign w_shift_rx = (r_state == ST_SHIFT) && spi_rise;
    assign w_shift_tx = (r_state == ST_SHIFT) && spi_fall && w_cnt_lt_len;

    prvp_spi_ctrl_shreg #(
        .DATA_W (DATA_W),
        .LEN_W  (c_LEN_W)
    ) u_shreg (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_shift_tx   (w_shift_tx),
        .i_shift_rx   (w_shift_rx),
        .i_len        (bus.req_len),
        .i_wdata      (bus.req_wdata),
        .i_miso       (spi_miso),
        .o_mosi       (spi_mosi),
        .o_rdata      (w_rdata),
        .o_cnt_lt_len (w_cnt_lt_len),
        .o_cnt_last   (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_cs_n      <= 1'b1;
            r_clkgen_en <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_tmr       <= '0;
                        // Zero-length requests answer immediately without touching the bus.
                        if (bus.req_len == '0) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_cs_n  <= 1'b0;
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_tmr == c_SETUP_LAST) begin
                        r_clkgen_en <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (spi_rise && w_cnt_last) begin
                        r_state <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    // Dropping the enable on a fall parks the generator with SCK low.
                    if (spi_fall) begin
                        r_clkgen_en <= 1'b0;
                        r_tmr       <= '0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_tmr == c_HOLD_LAST) begin
                        r_cs_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = w_rdata;
    assign bus.busy      = r_busy;
    assign spi_cs_n      = r_cs_n;
    assign clkgen_en     = r_clkgen_en;

    assign w_unused_spi_clk = spi_clk;

endmodule
`default_nettype wire
